// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM capture block.
//   pdm_state_e : sequencer states, readable through the STAT register
//   REG_*       : register offsets of the peripheral window
//   MIN_DIV     : smallest usable PDM period in clk cycles
package pdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } pdm_state_e;

  localparam logic [3:0] REG_CTRL = 4'h0;
  localparam logic [3:0] REG_CLKP = 4'h4;
  localparam logic [3:0] REG_PCM  = 4'h8;
  localparam logic [3:0] REG_STAT = 4'hC;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/pdm_pcm_fifo.sv
// DEPTH x PCM_W synchronous FIFO for PCM words.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and word; ignored when full unless popping
//   pop        : read request; ignored when empty
//   level      : occupancy 0..DEPTH
//   head       : registered head word, 0 when empty
module pdm_pcm_fifo #(
  parameter int DEPTH = 8,
  parameter int PCM_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [PCM_W-1:0]         din,
  output logic [$clog2(DEPTH):0]   level,
  output logic [PCM_W-1:0]         head
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [PCM_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0]    count_reg, count_next;
  logic [PCM_W-1:0] head_reg;
  logic             full, wr_en, rd_ok;

  assign full  = (count_reg == LW'(DEPTH));
  assign rd_ok = pop && (count_reg != '0);
  // A pop frees the slot the push is aimed at, so push+pop at full is accepted.
  assign wr_en = push && (!full || rd_ok);

  always_comb begin
    rd_ptr_next = rd_ptr_reg + AW'(rd_ok);
    count_next  = count_reg;
    if (wr_en && !rd_ok)      count_next = count_reg + LW'(1);
    else if (!wr_en && rd_ok) count_next = count_reg - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      // The new head may be the word being written this cycle; bypass it.
      if (count_next == '0)
        head_reg <= '0;
      else if (wr_en && (wr_ptr_reg == rd_ptr_next))
        head_reg <= din;
      else
        head_reg <= mem[rd_ptr_next];
    end
  end

  assign level = count_reg;
  assign head  = head_reg;

endmodule

// File: rtl/pdm_capture_ctrl.sv
// PDM capture sequencer: generates the microphone clock and the CIC clock
// enable, drops warm-up samples after each start, buffers PCM words and
// raises the interrupt on threshold or overrun.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   enable, clk_div     : capture enable, PDM period (0/1 treated as 2)
//   warm_cnt            : CIC outputs discarded after each start
//   fifo_thr, irq_en    : IRQ threshold (0 = off), interrupt enable
//   clr_ovr             : clears the sticky overrun flag
//   pdm_clk, pdm_tick   : PDM pin clock, one-cycle CIC enable on its rising edge
//   pcm_in, pcm_valid   : CIC output word and strobe
//   rd_en, rd_data      : pop pulse, FIFO head (0 when empty)
//   level, overrun      : occupancy, sticky drop flag
//   state, irq          : FSM state, interrupt request
module pdm_capture_ctrl
  import pdm_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int PCM_W  = 16,
  parameter int DIV_W  = 8,
  parameter int WARM_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [DIV_W-1:0]       clk_div,
  input  logic [WARM_W-1:0]      warm_cnt,
  input  logic [$clog2(DEPTH):0] fifo_thr,
  input  logic                   irq_en,
  input  logic                   clr_ovr,
  output logic                   pdm_clk,
  output logic                   pdm_tick,
  input  logic [PCM_W-1:0]       pcm_in,
  input  logic                   pcm_valid,
  input  logic                   rd_en,
  output logic [PCM_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overrun,
  output logic [1:0]             state,
  output logic                   irq
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  pdm_state_e        state_reg;
  logic [DIV_W-1:0]  phase_reg, per_reg, clk_div_eff;
  logic [WARM_W-1:0] warm_reg;
  logic              pdm_clk_reg, pdm_tick_reg, overrun_reg, irq_reg;
  logic              push, full, drop;
  logic [LVL_W-1:0]  fifo_level;

  assign clk_div_eff = (clk_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : clk_div;

  // The sample that ends warm-up is already a keeper.
  assign push = pcm_valid && ((state_reg == ST_RUN) ||
                              (state_reg == ST_WARMUP && warm_reg == '0));
  assign full = (fifo_level == LVL_W'(DEPTH));
  assign drop = push && full && !rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      phase_reg    <= '0;
      per_reg      <= '0;
      warm_reg     <= '0;
      pdm_clk_reg  <= 1'b0;
      pdm_tick_reg <= 1'b0;
    end else if (!enable) begin
      state_reg    <= ST_IDLE;
      phase_reg    <= '0;
      per_reg      <= clk_div_eff;
      warm_reg     <= '0;
      pdm_clk_reg  <= 1'b0;
      pdm_tick_reg <= 1'b0;
    end else if (state_reg == ST_IDLE) begin
      state_reg    <= ST_WARMUP;
      phase_reg    <= '0;
      per_reg      <= clk_div_eff;
      warm_reg     <= warm_cnt;
      pdm_clk_reg  <= 1'b0;
      pdm_tick_reg <= 1'b0;
    end else begin
      // Period is only resampled at the wrap so a divider write never
      // produces a runt cycle on the pin.
      if (phase_reg == per_reg - DIV_W'(1)) begin
        phase_reg <= '0;
        per_reg   <= clk_div_eff;
      end else begin
        phase_reg <= phase_reg + DIV_W'(1);
      end
      pdm_clk_reg  <= (phase_reg < (per_reg >> 1));
      pdm_tick_reg <= (phase_reg == '0);
      if (state_reg == ST_WARMUP && pcm_valid) begin
        if (warm_reg == '0) state_reg <= ST_RUN;
        else                warm_reg  <= warm_reg - WARM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_reg <= 1'b0;
      irq_reg     <= 1'b0;
    end else begin
      // A new drop wins over a simultaneous clear.
      if (drop)         overrun_reg <= 1'b1;
      else if (clr_ovr) overrun_reg <= 1'b0;
      irq_reg <= irq_en && (overrun_reg ||
                            (fifo_thr != '0 && fifo_level >= fifo_thr));
    end
  end

  pdm_pcm_fifo #(
    .DEPTH (DEPTH),
    .PCM_W (PCM_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (rd_en),
    .din   (pcm_in),
    .level (fifo_level),
    .head  (rd_data)
  );

  assign pdm_clk  = pdm_clk_reg;
  assign pdm_tick = pdm_tick_reg;
  assign level    = fifo_level;
  assign overrun  = overrun_reg;
  assign state    = state_reg;
  assign irq      = irq_reg;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
module tb_pdm_capture_ctrl;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [7:0]  clk_div, warm_cnt;
  logic [3:0]  fifo_thr;
  logic        irq_en, clr_ovr;
  logic        pdm_clk, pdm_tick;
  logic [15:0] pcm_in;
  logic        pcm_valid, rd_en;
  logic [15:0] rd_data;
  logic [3:0]  level;
  logic        overrun;
  logic [1:0]  state;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Reference model: queue-based FIFO, sample counting since start.
  logic [15:0] q[$];
  bit          m_ovr, m_irq;
  int          m_state, m_disc, m_target;

  typedef struct {
    logic        rd;
    logic        vld;
    logic [15:0] din;
    logic [3:0]  exp_level;
    logic [15:0] exp_rd;
    logic        exp_ovr;
    logic        exp_irq;
  } vec_t;
  vec_t vecs[11];

  always #5 clk = ~clk;

  pdm_capture_ctrl #(.DEPTH(DEPTH), .PCM_W(16), .DIV_W(8), .WARM_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clk_div(clk_div),
    .warm_cnt(warm_cnt), .fifo_thr(fifo_thr), .irq_en(irq_en),
    .clr_ovr(clr_ovr), .pdm_clk(pdm_clk), .pdm_tick(pdm_tick),
    .pcm_in(pcm_in), .pcm_valid(pcm_valid), .rd_en(rd_en),
    .rd_data(rd_data), .level(level), .overrun(overrun), .state(state),
    .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovr = 0; m_irq = 0; m_state = 0; m_disc = 0; m_target = 0;
  endtask

  // Advance one clock; the model consumes the inputs seen at that edge.
  task automatic step();
    bit pop_ok, push, drop, nirq;
    pop_ok = rd_en && (q.size() > 0);
    push   = pcm_valid && (m_state == 2 || (m_state == 1 && m_disc == m_target));
    nirq   = irq_en && (m_ovr || (fifo_thr != 0 && q.size() >= int'(fifo_thr)));
    drop   = 0;
    if (pop_ok) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(pcm_in);
      else drop = 1;
    end
    m_ovr = drop ? 1'b1 : (clr_ovr ? 1'b0 : m_ovr);
    m_irq = nirq;
    if (!enable) m_state = 0;
    else if (m_state == 0) begin
      m_state = 1; m_disc = 0; m_target = int'(warm_cnt);
    end else if (m_state == 1 && pcm_valid) begin
      if (m_disc == m_target) m_state = 2;
      else m_disc++;
    end
    @(posedge clk); #1;
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_level"}, level, q.size());
    check({tag, "_rd_data"}, rd_data, (q.size() > 0) ? q[0] : 16'h0);
    check({tag, "_overrun"}, overrun, m_ovr);
    check({tag, "_irq"}, irq, m_irq);
    check({tag, "_state"}, state, m_state);
    if (m_state == 0) check({tag, "_pdm_clk_idle"}, pdm_clk, 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    enable = 0; rd_en = 0; pcm_valid = 0; clr_ovr = 0; pcm_in = 0;
    #1;
    check({tag, "_rst_state"}, state, 0);
    check({tag, "_rst_pdm_clk"}, pdm_clk, 0);
    check({tag, "_rst_tick"}, pdm_tick, 0);
    check({tag, "_rst_level"}, level, 0);
    check({tag, "_rst_rd_data"}, rd_data, 0);
    check({tag, "_rst_overrun"}, overrun, 0);
    check({tag, "_rst_irq"}, irq, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    $display("reset %s done", tag);
  endtask

  task automatic wait_tick();
    int n = 0;
    step();
    while (!pdm_tick && n < 300) begin step(); n++; end
    check("tick_timeout", pdm_tick, 1);
  endtask

  task automatic measure(input int ehi, input int elo, input string tag);
    int hi = 0, lo = 0, ticks = 0;
    wait_tick(); wait_tick();
    for (int k = 0; k < ehi + elo; k++) begin
      if (pdm_clk) hi++; else lo++;
      if (pdm_tick) ticks++;
      step();
    end
    check({tag, "_high"}, hi, ehi);
    check({tag, "_low"}, lo, elo);
    check({tag, "_ticks"}, ticks, 1);
    check({tag, "_next_tick"}, pdm_tick, 1);
    $display("clock %s high=%0d low=%0d ticks=%0d", tag, hi, lo, ticks);
  endtask

  task automatic push_word(input logic [15:0] w);
    pcm_in = w; pcm_valid = 1; step(); pcm_valid = 0;
  endtask

  initial begin
    vecs[0]  = '{0, 1, 16'hA001, 4'd1, 16'hA001, 0, 0};
    vecs[1]  = '{0, 1, 16'hA002, 4'd2, 16'hA001, 0, 0};
    vecs[2]  = '{0, 1, 16'hA003, 4'd3, 16'hA001, 0, 0};
    vecs[3]  = '{0, 1, 16'hA004, 4'd4, 16'hA001, 0, 0};
    vecs[4]  = '{0, 0, 16'h0000, 4'd4, 16'hA001, 0, 1};
    vecs[5]  = '{1, 0, 16'h0000, 4'd3, 16'hA002, 0, 1};
    vecs[6]  = '{0, 0, 16'h0000, 4'd3, 16'hA002, 0, 0};
    vecs[7]  = '{1, 0, 16'h0000, 4'd2, 16'hA003, 0, 0};
    vecs[8]  = '{1, 0, 16'h0000, 4'd1, 16'hA004, 0, 0};
    vecs[9]  = '{1, 0, 16'h0000, 4'd0, 16'h0000, 0, 0};
    vecs[10] = '{1, 0, 16'h0000, 4'd0, 16'h0000, 0, 0};

    clk_div = 8'd10; warm_cnt = 8'd200; fifo_thr = 0; irq_en = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clock generation
    do_reset("clk");
    enable = 1;
    measure(5, 5, "div10");
    clk_div = 8'd7;
    measure(3, 4, "div7");
    clk_div = 8'd1;
    measure(1, 1, "div1");

    // Threshold IRQ and pop order, table-driven
    do_reset("table");
    warm_cnt = 0; clk_div = 8'd4; fifo_thr = 4'd4; irq_en = 1; enable = 1;
    step();
    for (int i = 0; i < 11; i++) begin
      rd_en = vecs[i].rd; pcm_valid = vecs[i].vld; pcm_in = vecs[i].din;
      step();
      rd_en = 0; pcm_valid = 0;
      check($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
      check($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_rd);
      check($sformatf("vec%0d_overrun", i), overrun, vecs[i].exp_ovr);
      check($sformatf("vec%0d_irq", i), irq, vecs[i].exp_irq);
      $display("vec %0d rd=%0b vld=%0b level=%0d rd_data=%h ovr=%0b irq=%0b",
               i, vecs[i].rd, vecs[i].vld, level, rd_data, overrun, irq);
    end

    // Warm-up discard with tick-aligned CIC strobes
    do_reset("warm");
    clk_div = 8'd4; warm_cnt = 8'd3; fifo_thr = 0; irq_en = 0; enable = 1;
    for (int w = 0; w < 5; w++) begin
      wait_tick();
      push_word(16'h0011 + 16'(w));
    end
    check("warm_level", level, 2);
    check("warm_head", rd_data, 16'h0014);
    check("warm_state", state, 2);
    rd_en = 1; step(); rd_en = 0;
    check("warm_pop_head", rd_data, 16'h0015);
    check("warm_pop_level", level, 1);

    // Disable from RUN, WARMUP, and restart of warm-up
    enable = 0; step();
    check("dis_run_state", state, 0);
    check("dis_run_pdm_clk", pdm_clk, 0);
    check("dis_run_level", level, 1);
    warm_cnt = 8'd2; enable = 1; step();
    push_word(16'h0101);
    enable = 0; step();
    check("dis_warm_state", state, 0);
    check("dis_warm_pdm_clk", pdm_clk, 0);
    check("dis_warm_level", level, 1);
    enable = 1; step();
    push_word(16'h0102); push_word(16'h0103);
    check("rewarm_level", level, 1);
    check("rewarm_state", state, 1);
    push_word(16'h0104);
    check("rewarm_keep_level", level, 2);
    check("rewarm_run", state, 2);
    enable = 0; step();
    check("dis_run2_state", state, 0);
    check("dis_run2_level", level, 2);
    $display("enable sequence level=%0d state=%0d", level, state);

    // Full, overrun, clear, push+pop at full
    do_reset("full");
    warm_cnt = 0; clk_div = 8'd5; fifo_thr = 0; irq_en = 1; enable = 1;
    step();
    for (int i = 0; i < 8; i++) push_word(16'hB000 + 16'(i));
    check("full_level", level, 8);
    check("full_irq_off", irq, 0);
    push_word(16'hBEEF);
    check("drop_level", level, 8);
    check("drop_overrun", overrun, 1);
    check("drop_head", rd_data, 16'hB000);
    step();
    check("ovr_irq", irq, 1);
    clr_ovr = 1; step(); clr_ovr = 0;
    check("clr_overrun", overrun, 0);
    step(); step();
    check("clr_irq", irq, 0);
    rd_en = 1; push_word(16'hC0DE); rd_en = 0;
    check("pp_level", level, 8);
    check("pp_overrun", overrun, 0);
    check("pp_head", rd_data, 16'hB001);
    clr_ovr = 1; push_word(16'hDEAD); clr_ovr = 0;
    check("clr_drop_overrun", overrun, 1);
    clr_ovr = 1; step(); clr_ovr = 0;
    rd_en = 1;
    for (int i = 0; i < 7; i++) step();
    rd_en = 0;
    check("tail_level", level, 1);
    check("tail_word", rd_data, 16'hC0DE);
    $display("full sequence level=%0d head=%h", level, rd_data);

    // Reset mid-RUN
    do_reset("midrun");
    warm_cnt = 0; clk_div = 8'd6; fifo_thr = 4'd4; irq_en = 1; enable = 1;
    step();
    for (int i = 0; i < 5; i++) push_word(16'hD000 + 16'(i));
    wait_tick();
    check("pre_rst_level", level, 5);
    check("pre_rst_irq", irq, 1);
    check("pre_rst_pdm_clk", pdm_clk, 1);
    do_reset("midrun2");
    rd_en = 1; step(); rd_en = 0;
    check("empty_pop_rd_data", rd_data, 0);
    check("empty_pop_level", level, 0);

    // Randomized traffic against the reference model
    do_reset("rand");
    warm_cnt = 8'($urandom_range(0, 3)); clk_div = 8'($urandom_range(0, 9));
    fifo_thr = 4'($urandom_range(0, 8)); irq_en = 1; enable = 1;
    for (int c = 0; c < 600; c++) begin
      pcm_valid = ($urandom_range(0, 1) == 1);
      pcm_in    = 16'($urandom);
      rd_en     = ($urandom_range(0, 2) == 0);
      clr_ovr   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if ($urandom_range(0, 63) == 0) fifo_thr = 4'($urandom_range(0, 8));
      if ($urandom_range(0, 63) == 0) irq_en = ~irq_en;
      if ($urandom_range(0, 63) == 0) warm_cnt = 8'($urandom_range(0, 3));
      step();
      compare_model($sformatf("rand%0d", c));
    end
    pcm_valid = 0; rd_en = 0; clr_ovr = 0;
    $display("random phase done level=%0d", level);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
